// File: rtl/memory_pkg.sv
// Shared types and constants for the simple-dual-port RAM and its clear sequencer.
package memory_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/mem_clear_fsm.sv
// Post-reset clear sequencer: walks every address once, writing zero, then
// parks in ST_READY until the next reset.
module mem_clear_fsm
    import memory_pkg::*;
#(
    parameter  int DEPTH          = 256,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int ADDR_W         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam mem_state_t        RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_READY: begin
            end
        endcase
    end

    assign clr_addr = cnt_q;
    assign busy     = (state_q == ST_CLEAR);

endmodule

// File: rtl/memory_dp.sv
// Simple-dual-port synchronous RAM with registered read, selectable
// read-during-write behaviour and an optional post-reset zero sweep.
module memory_dp
    import memory_pkg::*;
#(
    parameter  int WIDTH          = 8,
    parameter  int DEPTH          = 256,
    parameter  int RDW_MODE       = RDW_READ_FIRST,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int ADDR_W         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              busy
);

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              waddr_ok, raddr_ok;
    logic              user_we, user_re;
    logic              ar_we;
    logic [ADDR_W-1:0] ar_addr;
    logic [WIDTH-1:0]  ar_wdata;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    mem_clear_fsm #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A power-of-two depth makes every encodable address legal.
    if (DEPTH == (1 << ADDR_W)) begin : g_full_range
        assign waddr_ok = 1'b1;
        assign raddr_ok = 1'b1;
    end else begin : g_bounded
        localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
        assign waddr_ok = (waddr <= LAST_ADDR);
        assign raddr_ok = (raddr <= LAST_ADDR);
    end

    assign user_we = we & ~busy & waddr_ok;
    assign user_re = re & ~busy;

    always_comb begin
        if (clr_we) begin
            ar_we    = 1'b1;
            ar_addr  = clr_addr;
            ar_wdata = '0;
        end else begin
            ar_we    = user_we;
            ar_addr  = waddr;
            ar_wdata = wdata;
        end
    end

    // NOTE: the array has no reset term; zeroing it is the sweep's job, which
    // keeps it mappable onto block RAM.
    always_ff @(posedge clk) begin
        if (ar_we) begin
            mem_q[ar_addr] <= ar_wdata;
        end
    end

    // Reading mem_q before the edge yields old data; write-first forwards wdata.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (user_re) begin
            rvalid_d = 1'b1;
            if (!raddr_ok) begin
                rdata_d = '0;
            end else if (RDW_MODE == RDW_WRITE_FIRST && user_we && waddr == raddr) begin
                rdata_d = wdata;
            end else begin
                rdata_d = mem_q[raddr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_memory_dp.sv
// Directed bench for memory_dp: three instances (256/read-first, 256/write-first,
// 200/read-first) share one stimulus stream and are checked against a small model.
module tb_memory_dp;

    logic       clk = 1'b0;
    logic       rst;
    logic       we, re;
    logic [7:0] waddr, raddr, wdata;
    logic [7:0] rdata0, rdata1, rdata2;
    logic       rvalid0, rvalid1, rvalid2;
    logic       busy0, busy1, busy2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] model0 [256];
    logic [7:0] model2 [256];

    always #5 clk = ~clk;

    memory_dp #(.WIDTH(8), .DEPTH(256), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0), .busy(busy0));

    memory_dp #(.WIDTH(8), .DEPTH(256), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1));

    memory_dp #(.WIDTH(8), .DEPTH(200), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re),
        .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2), .busy(busy2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 256; i++) begin
            model0[i] = 8'h00;
            model2[i] = 8'h00;
        end
    endtask

    // Counts edges after reset release until each instance drops busy.
    task automatic wait_sweep(input bit junk, output int e0, output int e1, output int e2,
                              output int rv_seen);
        e0 = 0; e1 = 0; e2 = 0; rv_seen = 0;
        for (int n = 1; n <= 1000; n++) begin
            if (junk && n < 190) begin
                we = 1'b1; wdata = 8'hFF; re = 1'b1;
                waddr = 8'(n); raddr = 8'(n);
            end else begin
                we = 1'b0; re = 1'b0;
            end
            step();
            if (rvalid0 || rvalid1 || rvalid2) rv_seen++;
            if (e0 == 0 && !busy0) e0 = n;
            if (e1 == 0 && !busy1) e1 = n;
            if (e2 == 0 && !busy2) e2 = n;
            if (e0 != 0 && e1 != 0 && e2 != 0) break;
        end
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [7:0] d);
        we = 1'b1; waddr = 8'(a); wdata = d;
        step();
        we = 1'b0;
        model0[a] = d;
        if (a < 200) model2[a] = d;
    endtask

    task automatic check_read(input int a);
        check($sformatf("d0_rdata_a%0d", a), rdata0, model0[a]);
        check($sformatf("d1_rdata_a%0d", a), rdata1, model0[a]);
        check($sformatf("d2_rdata_a%0d", a), rdata2, model2[a]);
        check($sformatf("rvalid_a%0d", a), {rvalid0, rvalid1, rvalid2}, 3'b111);
    endtask

    task automatic do_read(input int a);
        re = 1'b1; raddr = 8'(a);
        step();
        re = 1'b0;
        check_read(a);
    endtask

    // Back-to-back reads of every address, then one idle cycle.
    task automatic read_all();
        for (int i = 0; i < 256; i++) begin
            re = 1'b1; raddr = 8'(i);
            step();
            check_read(i);
        end
        re = 1'b0;
        step();
        check("rvalid_drop", {rvalid0, rvalid1, rvalid2}, 3'b000);
        check("rdata_hold", rdata0, model0[255]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, e2, rv;
        rst = 1'b0; we = 1'b0; re = 1'b0;
        waddr = '0; raddr = '0; wdata = '0;
        clear_models();

        // Reset state
        repeat (3) step();
        check("rst_rdata", rdata0, 8'h00);
        check("rst_rvalid", {rvalid0, rvalid1, rvalid2}, 3'b000);
        check("rst_busy", {busy0, busy1, busy2}, 3'b111);

        // Sweep length, with traffic attempted while busy
        rst = 1'b1;
        wait_sweep(1'b1, e0, e1, e2, rv);
        check("sweep_len_d0", e0, 256);
        check("sweep_len_d1", e1, 256);
        check("sweep_len_d2", e2, 200);
        check("rvalid_while_busy", rv, 0);
        check("rdata_held_busy", rdata0, 8'h00);
        read_all();

        // Fill with address pattern and read back
        for (int i = 0; i < 256; i++) do_write(i, 8'(i));
        read_all();

        // Out-of-range and last-address access on the 200-deep instance
        do_write(250, 8'h3C);
        do_read(250);
        do_write(199, 8'h5A);
        do_read(199);

        // Same-address read-during-write
        we = 1'b1; waddr = 8'd5; wdata = 8'hAA;
        re = 1'b1; raddr = 8'd5;
        step();
        we = 1'b0; re = 1'b0;
        check("rdw_d0_old", rdata0, 8'h05);
        check("rdw_d1_new", rdata1, 8'hAA);
        check("rdw_d2_old", rdata2, 8'h05);
        model0[5] = 8'hAA;
        model2[5] = 8'hAA;
        do_read(5);

        // Different addresses on one edge never interact
        we = 1'b1; waddr = 8'd6; wdata = 8'h77;
        re = 1'b1; raddr = 8'd7;
        step();
        we = 1'b0; re = 1'b0;
        check_read(7);
        model0[6] = 8'h77;
        model2[6] = 8'h77;
        do_read(6);

        // Asynchronous reset, then reset again mid-sweep
        rst = 1'b0;
        #1;
        check("async_rdata", rdata0, 8'h00);
        check("async_rvalid", {rvalid0, rvalid1, rvalid2}, 3'b000);
        check("async_busy", {busy0, busy1, busy2}, 3'b111);
        step();
        rst = 1'b1;
        repeat (100) step();
        check("midsweep_busy", {busy0, busy1, busy2}, 3'b111);
        rst = 1'b0;
        #1;
        check("midsweep_rdata", rdata0, 8'h00);
        step();
        rst = 1'b1;
        wait_sweep(1'b0, e0, e1, e2, rv);
        check("resweep_len_d0", e0, 256);
        check("resweep_len_d2", e2, 200);
        clear_models();
        do_read(150);
        do_read(250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
